// File: rtl/gpio_parity_checker.sv
// gpio_parity_checker: checks the parity of sampled 17-bit GPIO words and
// queues {err, data} entries in a small receive FIFO with error statistics.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   GPIOIN_i[16:0]      sampled word: [16] parity bit, [15:0] data
//   in_valid_i          GPIOIN_i carries a word this cycle
//   clear_i             clears err_cnt_o, err_sticky_o, overflow_o
//   data_o/data_err_o   FIFO head data and its stored parity-error flag
//   data_valid_o        FIFO non-empty
//   data_ready_i        consumer takes the head when data_valid_o is high
//   parity_err_o        one-cycle pulse after an accepted erroneous word
//   err_cnt_o           saturating parity-error count
//   err_sticky_o        any parity error since the last clear/reset
//   overflow_o          sticky: a word arrived while the FIFO was full
//   first_err_o/first_err_valid_o
//                       first erroneous raw word since clear/reset; present
//                       only when GPIO_PARITY_CHECKER_FIRST_ERR_EN is defined
module gpio_parity_checker #(
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [16:0]      GPIOIN_i,
  input  logic             in_valid_i,
  input  logic             clear_i,
  output logic [15:0]      data_o,
  output logic             data_err_o,
  output logic             data_valid_o,
  input  logic             data_ready_i,
  output logic             parity_err_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             err_sticky_o,
`ifdef GPIO_PARITY_CHECKER_FIRST_ERR_EN
  output logic [16:0]      first_err_o,
  output logic             first_err_valid_o,
`endif
  output logic             overflow_o
);

  localparam int unsigned WORD_W = 17;
  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW     = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_FULL} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic [WORD_W-1:0]   head_q, head_d;
  logic                valid_q, valid_d;
  logic                perr_q, perr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sticky_q, sticky_d;
  logic                ovf_q, ovf_d;
  logic [WORD_W-1:0]   ferr_q, ferr_d;
  logic                fval_q, fval_d;

  logic                push_c, pop_c, drop_c, err_c;
  logic [PW-1:0]       count_c;
  logic [WORD_W-1:0]   entry_c;
  logic [CNT_W-1:0]    cnt_base_c;
  logic                fval_base_c;

  // Next-state, FIFO control and statistics
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    head_d      = head_q;
    valid_d     = valid_q;
    perr_d      = 1'b0;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    ovf_d       = ovf_q;
    ferr_d      = ferr_q;
    fval_d      = fval_q;
    cnt_base_c  = cnt_q;
    fval_base_c = fval_q;

    // A parity mismatch for the selected sense flags the word
    err_c   = GPIOIN_i[16] ^ (^GPIOIN_i[15:0]) ^ PARITY_ODD;
    entry_c = {err_c, GPIOIN_i[15:0]};
    count_c = wr_ptr_q - rd_ptr_q;

    pop_c  = (state_q != ST_IDLE) && data_ready_i;
    push_c = in_valid_i && ((state_q != ST_FULL) || pop_c);
    drop_c = in_valid_i && (state_q == ST_FULL) && !pop_c;

    wr_ptr_d = wr_ptr_q + PW'(push_c);
    rd_ptr_d = rd_ptr_q + PW'(pop_c);

    unique case (state_q)
      ST_IDLE: begin
        if (push_c) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (push_c && !pop_c && (count_c == PW'(DEPTH - 1))) state_d = ST_FULL;
        else if (pop_c && !push_c && (count_c == PW'(1)))    state_d = ST_IDLE;
      end
      ST_FULL: begin
        if (pop_c && !push_c) state_d = ST_ACTIVE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered head: the slot being written now becomes the head only
    // when it is the next read position
    if (state_d == ST_IDLE) begin
      valid_d = 1'b0;
      head_d  = '0;
    end else begin
      valid_d = 1'b1;
      if (push_c && (rd_ptr_d == wr_ptr_q)) head_d = entry_c;
      else                                  head_d = mem_q[rd_ptr_d[AW-1:0]];
    end

    // clear_i applies before this cycle's error/overflow event
    perr_d = push_c && err_c;
    if (clear_i) begin
      cnt_base_c  = '0;
      fval_base_c = 1'b0;
      sticky_d    = 1'b0;
      ovf_d       = 1'b0;
      ferr_d      = '0;
    end
    cnt_d  = cnt_base_c;
    fval_d = fval_base_c;
    if (push_c && err_c) begin
      if (cnt_base_c != CNT_MAX) cnt_d = cnt_base_c + CNT_W'(1);
      sticky_d = 1'b1;
      if (!fval_base_c) begin
        ferr_d = GPIOIN_i;
        fval_d = 1'b1;
      end
    end
    if (drop_c) ovf_d = 1'b1;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
      ferr_q   <= '0;
      fval_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
      fval_q   <= fval_d;
    end
  end

  // FIFO storage; stale contents are unreachable once pointers reset
  always_ff @(posedge clk) begin
    if (!reset && push_c) mem_q[wr_ptr_q[AW-1:0]] <= entry_c;
  end

  assign data_o       = head_q[15:0];
  assign data_err_o   = head_q[16];
  assign data_valid_o = valid_q;
  assign parity_err_o = perr_q;
  assign err_cnt_o    = cnt_q;
  assign err_sticky_o = sticky_q;
  assign overflow_o   = ovf_q;
`ifdef GPIO_PARITY_CHECKER_FIRST_ERR_EN
  assign first_err_o       = ferr_q;
  assign first_err_valid_o = fval_q;
`endif

endmodule
